seq_decoder: RTL

Parametrised, registered N-to-2^N one-hot decoder with enable. It is the successor to the combinational 2-to-4 decoder and generalises it in width. It adds a scan mode in which an internal pointer steps through the outputs one per cycle, wrapping at the top. It is used as a row/port select driver for register-file and mux-select sequencing.

---
 rtl/seq_decoder_if.sv | 26 ++
 rtl/seq_decoder.sv | 78 +++++++
 2 files changed

// File: rtl/seq_decoder_if.sv
// seq_decoder_if: bundles the decoder's control inputs and select outputs.
// Optional feature macro: SEQ_DECODER_DIR_EN adds the scan direction signal dir.
interface seq_decoder_if #(
  parameter int ADDR_WIDTH = 2
);
  localparam int OUT_WIDTH = 32'd1 << ADDR_WIDTH;

  logic                  enable;
  logic                  mode;
  logic                  load;
  logic [ADDR_WIDTH-1:0] addr;
`ifdef SEQ_DECODER_DIR_EN
  logic                  dir;
`endif
  logic [OUT_WIDTH-1:0]  out;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  wrap;

`ifdef SEQ_DECODER_DIR_EN
  modport master (output enable, mode, load, addr, dir, input out, cur_addr, wrap);
  modport slave  (input enable, mode, load, addr, dir, output out, cur_addr, wrap);
`else
  modport master (output enable, mode, load, addr, input out, cur_addr, wrap);
  modport slave  (input enable, mode, load, addr, output out, cur_addr, wrap);
`endif
endinterface

// File: rtl/seq_decoder.sv
// seq_decoder: registered N-to-2^N one-hot decoder with a scan pointer that
// steps through the outputs one per fire, wrapping at the top address.
// Optional feature macro: SEQ_DECODER_DIR_EN (adds dir; dir=1 scans downward).
module seq_decoder #(
  parameter int ADDR_WIDTH = 2
) (
  input logic          clk,
  input logic          reset,
  seq_decoder_if.slave bus
);
  localparam int OUT_WIDTH = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] PTR_TOP  = {ADDR_WIDTH{1'b1}};
  localparam logic [OUT_WIDTH-1:0]  OUT_ZERO = {OUT_WIDTH{1'b0}};

  logic [ADDR_WIDTH-1:0] ptr_r;
  logic [ADDR_WIDTH-1:0] ptr_nxt_s;
  logic [OUT_WIDTH-1:0]  out_r;
  logic [OUT_WIDTH-1:0]  out_nxt_s;
  logic                  wrap_r;
  logic                  wrap_nxt_s;

  function automatic logic [OUT_WIDTH-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [OUT_WIDTH-1:0] v;
    v    = OUT_ZERO;
    v[a] = 1'b1;
    return v;
  endfunction

  // Next-state decode: load beats disable, disable beats any fire.
  always_comb begin
    ptr_nxt_s  = ptr_r;
    out_nxt_s  = OUT_ZERO;
    wrap_nxt_s = 1'b0;
    if (bus.mode && bus.load) begin
      // Pointer load never fires, whatever enable says.
      ptr_nxt_s = bus.addr;
    end else if (!bus.enable) begin
      ptr_nxt_s = ptr_r;
      out_nxt_s = OUT_ZERO;
    end else if (!bus.mode) begin
      // Direct decode leaves the scan pointer untouched so a scan can resume.
      out_nxt_s = onehot(bus.addr);
    end else begin
      out_nxt_s = onehot(ptr_r);
`ifdef SEQ_DECODER_DIR_EN
      if (bus.dir) begin
        ptr_nxt_s  = ptr_r - PTR_ONE;
        wrap_nxt_s = (ptr_r == PTR_ZERO);
      end else begin
        ptr_nxt_s  = ptr_r + PTR_ONE;
        wrap_nxt_s = (ptr_r == PTR_TOP);
      end
`else
      ptr_nxt_s  = ptr_r + PTR_ONE;
      wrap_nxt_s = (ptr_r == PTR_TOP);
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r  <= PTR_ZERO;
      out_r  <= OUT_ZERO;
      wrap_r <= 1'b0;
    end else begin
      ptr_r  <= ptr_nxt_s;
      out_r  <= out_nxt_s;
      wrap_r <= wrap_nxt_s;
    end
  end

  assign bus.out      = out_r;
  assign bus.cur_addr = ptr_r;
  assign bus.wrap     = wrap_r;
endmodule
